// File: rtl/riscv_fetch_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction-fetch front end.
package riscv_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned FETCH_BUF_DEPTH  = 2;
    localparam logic [1:0]  FETCH_CNT_FULL   = 2'd2;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer: head always in entry 0, push/pop/flush, count output.
module fetch_fifo
    import riscv_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_instr_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic        valid_o,
    output logic [31:0] head_pc_o,
    output logic [31:0] head_instr_o,
    output logic [1:0]  count_o
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    fetch_entry_t push_ent_s;
    logic [1:0]   count_q, count_d;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign push_ent_s = {push_pc_i, push_instr_i};
    assign pop_ok_s   = pop_i && (count_q != 2'd0);
    assign push_ok_s  = push_i && ((count_q < FETCH_CNT_FULL) || pop_ok_s);

    // Next-state for entries and occupancy; flush wins over any push or pop.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            ent0_d  = '0;
            ent1_d  = '0;
            count_d = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = push_ent_s;
                    end else begin
                        ent1_d = push_ent_s;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    ent1_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_ent_s;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_ent_s;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Buffer storage and occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    // Stale entry contents are masked so the head reads zero while empty.
    assign valid_o      = (count_q != 2'd0);
    assign head_pc_o    = valid_o ? ent0_q.pc    : 32'h0000_0000;
    assign head_instr_o = valid_o ? ent0_q.instr : 32'h0000_0000;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, redirect handling and fetch buffer to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_fault.
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] target_s;
    logic [1:0]  count_s;
    logic        fault_s;
    logic        pop_s;
    logic        push_s;

    assign imem_addr = pc_q;
    assign pop_s     = dec_valid && dec_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misalign_s;

    assign target_s   = redirect_target;
    assign misalign_s = redirect_valid && (redirect_target[1:0] != 2'b00);

    // Fault is sticky until reset.
    always_comb begin
        if (misalign_s) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q;
        end
    end

    // Fault flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_s     = fault_q;
    assign fetch_fault = fault_q;
`else
    assign target_s    = redirect_target & PC_ALIGN_MASK;
    assign fault_s     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // A pop in the same cycle frees the slot the push needs when the buffer is full.
    assign push_s = fetch_en && !redirect_valid && !fault_s &&
                    ((count_s < FETCH_CNT_FULL) || pop_s);

    // PC next-state: redirect first, then sequential advance on push.
    always_comb begin
        if (redirect_valid) begin
            pc_d = target_s;
        end else if (push_s) begin
            pc_d = pc_q + PC_INCR;
        end else begin
            pc_d = pc_q;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_s),
        .push_pc_i    (pc_q),
        .push_instr_i (imem_instr),
        .pop_i        (pop_s),
        .flush_i      (redirect_valid),
        .valid_o      (dec_valid),
        .head_pc_o    (dec_pc),
        .head_instr_o (dec_instr),
        .count_o      (count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model checked every cycle.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_pc;
    logic        m_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0013};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .fetch_fault     (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0000_0000;
        m_fault = 1'b0;
    endtask

    // Reference behaviour: a queue of {pc, instr}, capacity 2.
    task automatic model_step();
        bit    pop;
        bit    push;
        ment_t e;
        if (reset) begin
            model_reset();
        end else begin
            pop = (mq.size() > 0) && dec_ready;
            if (redirect_valid) begin
                mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = redirect_target;
                if (redirect_target[1:0] != 2'b00) m_fault = 1'b1;
`else
                m_pc = {redirect_target[31:2], 2'b00};
`endif
            end else begin
                push = fetch_en && !m_fault && ((mq.size() < 2) || pop);
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc    = m_pc;
                    e.instr = mem_word(m_pc);
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        ev  = (mq.size() > 0);
        epc = ev ? mq[0].pc : 32'h0000_0000;
        ein = ev ? mq[0].instr : 32'h0000_0000;
        chk("dec_valid", {31'd0, dec_valid}, {31'd0, ev});
        chk("dec_pc", dec_pc, epc);
        chk("dec_instr", dec_instr, ein);
        chk("imem_addr", imem_addr, m_pc);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        step();
        step();
    endtask

    initial begin
        reset           = 1'b1;
        fetch_en        = 1'b0;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
        model_reset();
        step();
        step();
        at_neg();
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_pc", dec_pc, 32'h0000_0000);
        chk("rst_instr", dec_instr, 32'h0000_0000);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // Streaming with decode always ready.
        step();
        reset     = 1'b0;
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            at_neg();
            chk("stream_pc", dec_pc, 32'(4 * k));
            chk("stream_instr", dec_instr, mem_word(32'(4 * k)));
        end

        // Decode stalled for four cycles, then released.
        do_reset();
        reset     = 1'b0;
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        at_neg();
        chk("stall_addr", imem_addr, 32'h0000_0008);
        chk("stall_head", dec_pc, 32'h0000_0000);
        dec_ready = 1'b1;
        step();
        at_neg();
        chk("release_pc1", dec_pc, 32'h0000_0004);
        step();
        at_neg();
        chk("release_pc2", dec_pc, 32'h0000_0008);

        // Redirect while the buffer is full.
        dec_ready = 1'b0;
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0028;
        dec_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        at_neg();
        chk("redir_valid", {31'd0, dec_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_0028);
        step();
        at_neg();
        chk("redir_pc", dec_pc, 32'h0000_0028);

        // Wrap-around of the PC.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        at_neg();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        at_neg();
        chk("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        step();
        at_neg();
        chk("wrap_pc1", dec_pc, 32'h0000_0000);

        // fetch_en low: pc holds while the buffer drains.
        fetch_en = 1'b0;
        step();
        at_neg();
        chk("hold_valid", {31'd0, dec_valid}, 32'd0);
        chk("hold_addr", imem_addr, 32'h0000_0004);
        step();
        at_neg();
        chk("hold_addr2", imem_addr, 32'h0000_0004);

        // Misaligned redirect.
        fetch_en        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0012;
        step();
        redirect_valid = 1'b0;
        at_neg();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_0012);
        step();
        at_neg();
        chk("mis_blocked", {31'd0, dec_valid}, 32'd0);
        step();
        at_neg();
        chk("mis_blocked2", {31'd0, dec_valid}, 32'd0);
`else
        chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
        chk("mis_addr", imem_addr, 32'h0000_0010);
        step();
        at_neg();
        chk("mis_pc", dec_pc, 32'h0000_0010);
`endif

        // Asynchronous reset with a full buffer.
        do_reset();
        reset     = 1'b0;
        dec_ready = 1'b0;
        step();
        step();
        at_neg();
        chk("full_head", dec_pc, 32'h0000_0000);
        chk("full_addr", imem_addr, 32'h0000_0008);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_valid", {31'd0, dec_valid}, 32'd0);
        chk("async_pc", dec_pc, 32'h0000_0000);
        chk("async_instr", dec_instr, 32'h0000_0000);
        chk("async_addr", imem_addr, 32'h0000_0000);
        step();
        reset     = 1'b0;
        dec_ready = 1'b1;
        step();
        at_neg();
        chk("restart_pc0", dec_pc, 32'h0000_0000);
        chk("restart_valid", {31'd0, dec_valid}, 32'd1);
        step();
        at_neg();
        chk("restart_pc1", dec_pc, 32'h0000_0004);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
